mult_arbiter: RTL

//   Sequences the shared 8-bit signed shift-add multiplier datapath (X/A/B registers,
//   9-bit add/sub adder) and shares it between NUM_REQ requesters.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mult_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the arbitrated shift-add multiplier sequencer.
package mult_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int MULT_STEPS = 8;
  localparam int CNT_W      = $clog2(MULT_STEPS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ADD     = 3'd2,
    SHIFT   = 3'd3,
    CAPTURE = 3'd4,
    RESP    = 3'd5
  } state_t;

  function automatic logic last_step(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(MULT_STEPS - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer;
// the pointer moves past the winner when the grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic [ID_W-1:0] ptr;

  always_comb begin
    int   idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (enable && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one signed shift-add multiplier datapath between NUM_REQ valid/ready requesters,
// sequencing load, 8 add/shift steps and product capture; every control output is registered.
//
//   state   | meaning
//   IDLE    | waiting for a request; only state that grants
//   LOAD    | clear X/A, load B with the multiplier
//   ADD     | add (or subtract on the sign bit) multiplicand when M=1
//   SHIFT   | arithmetic shift X->A->B, bump step counter
//   CAPTURE | latch {A,B} and owner id
//   RESP    | hold product until the consumer accepts
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = MULT_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_mcand,
  input  logic [NUM_REQ*WIDTH-1:0] req_mplier,
  output logic [WIDTH-1:0]         dp_S,
  output logic                     dp_Clr_Ld,
  output logic                     dp_Shift,
  output logic                     dp_Add,
  output logic                     dp_Sub,
  input  logic [WIDTH-1:0]         dp_A,
  input  logic [WIDTH-1:0]         dp_B,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     busy
);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [WIDTH-1:0]   mcand_q, mcand_next;
  logic [ID_W-1:0]    id_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gid;
  logic               hs;
  logic               arb_en;
  logic [WIDTH-1:0]   g_mcand, g_mplier;

  logic [WIDTH-1:0]   s_next;
  logic               clr_next, shift_next, add_next, sub_next, m_next;

  // Gating with Reset keeps req_ready low while the block is held in reset.
  assign arb_en    = (state == IDLE) && Reset;
  assign req_ready = grant;
  assign hs        = |(req_valid & grant);
  assign g_mcand   = req_mcand[int'(gid)*WIDTH +: WIDTH];
  assign g_mplier  = req_mplier[int'(gid)*WIDTH +: WIDTH];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk      (Clk),
    .rst_n    (Reset),
    .req      (req_valid),
    .enable   (arb_en),
    .advance  (hs),
    .grant    (grant),
    .grant_id (gid)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE:    if (hs) state_next = LOAD;
      LOAD:    begin
                 state_next = ADD;
                 cnt_next   = '0;
               end
      ADD:     state_next = SHIFT;
      SHIFT:   begin
                 cnt_next   = cnt + 1'b1;
                 state_next = last_step(cnt) ? CAPTURE : ADD;
               end
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered, so M for the coming ADD is predicted: entering from LOAD it is
  // bit 0 of the multiplier now on dp_S; entering from SHIFT it is dp_B[1], shifted in this edge.
  always_comb begin
    mcand_next = hs ? g_mcand : mcand_q;
    s_next     = mcand_next;
    clr_next   = 1'b0;
    shift_next = 1'b0;
    add_next   = 1'b0;
    sub_next   = 1'b0;
    m_next     = 1'b0;
    case (state_next)
      LOAD:  begin
               s_next   = g_mplier;
               clr_next = 1'b1;
             end
      ADD:   begin
               m_next = (state == LOAD) ? dp_S[0] : dp_B[1];
               if (m_next) begin
                 if (last_step(cnt_next)) sub_next = 1'b1;
                 else                     add_next = 1'b1;
               end
             end
      SHIFT: shift_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      mcand_q     <= '0;
      id_q        <= '0;
      dp_S        <= '0;
      dp_Clr_Ld   <= 1'b0;
      dp_Shift    <= 1'b0;
      dp_Add      <= 1'b0;
      dp_Sub      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      busy        <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      mcand_q   <= mcand_next;
      if (hs) id_q <= gid;
      dp_S      <= s_next;
      dp_Clr_Ld <= clr_next;
      dp_Shift  <= shift_next;
      dp_Add    <= add_next;
      dp_Sub    <= sub_next;
      rsp_valid <= (state_next == RESP);
      busy      <= (state_next != IDLE);
      if (state == CAPTURE) begin
        rsp_product <= {dp_A, dp_B};
        rsp_id      <= id_q;
      end
    end
  end

endmodule
